// File: rtl/fetch_sequencer_if.sv
// Control-path bundle between the fetch sequencer, instruction memory and decoder.
// The master modport is the sequencer side.
interface fetch_sequencer_if #(
  parameter int SC_WIDTH = 3,
  parameter int DATA_W   = 8
);
  logic                     SC_Clear;
  logic                     Stall;
  logic [DATA_W-1:0]        Mem_Data;
  logic                     Mem_CS;
  logic                     Mem_WR;
  logic                     IR_Enable;
  logic                     IR_LH;
  logic                     PC_Inc;
  logic [SC_WIDTH-1:0]      T_out;
  logic [2**SC_WIDTH-1:0]   T_onehot;
  logic [2*DATA_W-1:0]      IR_out;
  logic                     IR_Valid;
  logic                     Timeout;

  modport master (
    input  SC_Clear, Stall, Mem_Data,
    output Mem_CS, Mem_WR, IR_Enable, IR_LH, PC_Inc,
           T_out, T_onehot, IR_out, IR_Valid, Timeout
  );

  modport slave (
    output SC_Clear, Stall, Mem_Data,
    input  Mem_CS, Mem_WR, IR_Enable, IR_LH, PC_Inc,
           T_out, T_onehot, IR_out, IR_Valid, Timeout
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Timing-state counter T0..T7 with a two-byte instruction fetch in T0/T1.
// Handshake: Stall freezes the counter and masks the load/increment strobes; SC_Clear is honoured only in T2..T7 without Stall.
module fetch_sequencer #(
  parameter int SC_WIDTH = 3,
  parameter int DATA_W   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  fetch_sequencer_if.master bus
);

  localparam logic [SC_WIDTH-1:0] T_FIRST = '0;
  localparam logic [SC_WIDTH-1:0] T_HIGH  = SC_WIDTH'(1);
  localparam logic [SC_WIDTH-1:0] T_LAST  = '1;

  logic [SC_WIDTH-1:0]  t_q, t_d;
  logic [2*DATA_W-1:0]  ir_q, ir_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;
  logic                 is_t0, is_t1, fetching;

  assign is_t0    = (t_q == T_FIRST);
  assign is_t1    = (t_q == T_HIGH);
  assign fetching = is_t0 | is_t1;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      t_q       <= T_FIRST;
      ir_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      t_q       <= t_d;
      ir_q      <= ir_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state: the fetch is atomic, so SC_Clear only matters once the IR is full.
  // IR_Valid drops on every entry to T0 so the decoder never sees a stale instruction.
  always_comb begin
    t_d       = t_q;
    ir_d      = ir_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    if (!bus.Stall) begin
      if (is_t0) begin
        ir_d[DATA_W-1:0] = bus.Mem_Data;
        valid_d          = 1'b0;
        t_d              = T_HIGH;
      end else if (is_t1) begin
        ir_d[2*DATA_W-1:DATA_W] = bus.Mem_Data;
        valid_d                 = 1'b1;
        t_d                     = t_q + SC_WIDTH'(1);
      end else if (bus.SC_Clear) begin
        t_d     = T_FIRST;
        valid_d = 1'b0;
      end else begin
        t_d = t_q + SC_WIDTH'(1);
        if (t_q == T_LAST) begin
          timeout_d = 1'b1;
          valid_d   = 1'b0;
        end
      end
    end
  end

  // Outputs: chip select stays low through a stall so the read data remains valid.
  always_comb begin
    bus.Mem_CS          = ~(fetching & ~Reset);
    bus.Mem_WR          = 1'b0;
    bus.IR_Enable       = fetching & ~bus.Stall & ~Reset;
    bus.PC_Inc          = fetching & ~bus.Stall & ~Reset;
    bus.IR_LH           = is_t1;
    bus.T_out           = t_q;
    bus.T_onehot        = '0;
    bus.T_onehot[t_q]   = 1'b1;
    bus.IR_out          = ir_q;
    bus.IR_Valid        = valid_q;
    bus.Timeout         = timeout_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed checks of fetch_sequencer: fetch, clear, stall, wrap/timeout and reset mid-fetch.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   chk_count  = 0;
  int   fail_count = 0;
  int   pc_cnt     = 0;

  fetch_sequencer_if #(.SC_WIDTH(3), .DATA_W(8)) bus ();

  fetch_sequencer #(.SC_WIDTH(3), .DATA_W(8)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are changed 1 ns after an edge; outputs are sampled 1 ns later.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    #1;
    if (bus.PC_Inc === 1'b1) pc_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.SC_Clear = 1'b0;
    bus.Stall    = 1'b0;
    bus.Mem_Data = 8'h00;

    // Reset held two cycles: strobes forced inactive
    tick();
    settle();
    check("rst_mem_cs", 32'(bus.Mem_CS), 32'd1);
    check("rst_pc_inc", 32'(bus.PC_Inc), 32'd0);
    check("rst_ir_en", 32'(bus.IR_Enable), 32'd0);
    tick();

    // 1. first fetch 0x34, 0x12
    rst = 1'b0;
    bus.Mem_Data = 8'h34;
    pc_cnt = 0;
    settle();
    check("t0_state", 32'(bus.T_out), 32'd0);
    check("t0_pc_inc", 32'(bus.PC_Inc), 32'd1);
    check("t0_ir_lh", 32'(bus.IR_LH), 32'd0);
    check("t0_ir_en", 32'(bus.IR_Enable), 32'd1);
    check("t0_mem_cs", 32'(bus.Mem_CS), 32'd0);
    check("mem_wr", 32'(bus.Mem_WR), 32'd0);
    check("t0_ir_out", 32'(bus.IR_out), 32'h0000);
    check("t0_valid", 32'(bus.IR_Valid), 32'd0);
    check("t0_timeout", 32'(bus.Timeout), 32'd0);
    check("t0_onehot", 32'(bus.T_onehot), 32'h01);
    tick();
    bus.Mem_Data = 8'h12;
    settle();
    check("t1_state", 32'(bus.T_out), 32'd1);
    check("t1_ir_lh", 32'(bus.IR_LH), 32'd1);
    check("t1_pc_inc", 32'(bus.PC_Inc), 32'd1);
    check("t1_valid", 32'(bus.IR_Valid), 32'd0);
    tick();
    bus.Mem_Data = 8'hFF;
    settle();
    check("t2_ir_out", 32'(bus.IR_out), 32'h1234);
    check("t2_valid", 32'(bus.IR_Valid), 32'd1);
    check("t2_onehot", 32'(bus.T_onehot), 32'h04);
    check("t2_pc_inc", 32'(bus.PC_Inc), 32'd0);
    check("t2_mem_cs", 32'(bus.Mem_CS), 32'd1);
    check("t2_ir_en", 32'(bus.IR_Enable), 32'd0);

    // 2. SC_Clear in T2 ends the instruction after 3 cycles
    bus.SC_Clear = 1'b1;
    tick();
    check("instr1_pc_pulses", 32'(pc_cnt), 32'd2);
    bus.SC_Clear = 1'b0;
    bus.Mem_Data = 8'hCD;
    pc_cnt = 0;
    settle();
    check("clr_state", 32'(bus.T_out), 32'd0);
    check("clr_valid", 32'(bus.IR_Valid), 32'd0);
    check("clr_pc_inc", 32'(bus.PC_Inc), 32'd1);
    tick();

    // 3. stall three cycles in T1; data changes while stalled must not load
    bus.Stall    = 1'b1;
    bus.Mem_Data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("stall%0d_state", i), 32'(bus.T_out), 32'd1);
      check($sformatf("stall%0d_pc_inc", i), 32'(bus.PC_Inc), 32'd0);
      check($sformatf("stall%0d_ir_en", i), 32'(bus.IR_Enable), 32'd0);
      check($sformatf("stall%0d_mem_cs", i), 32'(bus.Mem_CS), 32'd0);
      tick();
    end
    check("stall_ir_hold", 32'(bus.IR_out), 32'h12CD);
    check("stall_valid", 32'(bus.IR_Valid), 32'd0);
    bus.Stall    = 1'b0;
    bus.Mem_Data = 8'hAB;
    settle();
    check("unstall_pc_inc", 32'(bus.PC_Inc), 32'd1);
    tick();
    bus.Mem_Data = 8'h00;
    settle();
    check("unstall_state", 32'(bus.T_out), 32'd2);
    check("unstall_ir_out", 32'(bus.IR_out), 32'hABCD);
    check("unstall_valid", 32'(bus.IR_Valid), 32'd1);
    check("instr2_pc_pulses", 32'(pc_cnt), 32'd2);

    // 6a. SC_Clear held from T2 into T0: ignored in T0
    bus.SC_Clear = 1'b1;
    tick();
    bus.Mem_Data = 8'h78;
    settle();
    check("sc_t0_state", 32'(bus.T_out), 32'd0);
    tick();
    bus.SC_Clear = 1'b0;
    bus.Mem_Data = 8'h56;
    settle();
    check("sc_t0_ignored", 32'(bus.T_out), 32'd1);
    tick();
    check("fetch3_ir_out", 32'(bus.IR_out), 32'h5678);
    tick();
    // 6b. SC_Clear with Stall in T3: lost
    bus.Stall    = 1'b1;
    bus.SC_Clear = 1'b1;
    settle();
    check("t3_state", 32'(bus.T_out), 32'd3);
    tick();
    check("stall_clr_state", 32'(bus.T_out), 32'd3);
    bus.Stall    = 1'b0;
    bus.SC_Clear = 1'b0;
    tick();
    check("t4_state", 32'(bus.T_out), 32'd4);

    // 4. no SC_Clear: run to T7 and wrap with Timeout
    for (int t = 5; t <= 7; t++) begin
      tick();
      check($sformatf("run_t%0d", t), 32'(bus.T_out), 32'(t));
      check($sformatf("run_t%0d_onehot", t), 32'(bus.T_onehot), 32'(1) << t);
      check($sformatf("run_t%0d_timeout", t), 32'(bus.Timeout), 32'd0);
    end
    tick();
    bus.Mem_Data = 8'h11;
    settle();
    check("wrap_state", 32'(bus.T_out), 32'd0);
    check("wrap_timeout", 32'(bus.Timeout), 32'd1);
    check("wrap_valid", 32'(bus.IR_Valid), 32'd0);
    tick();
    bus.Mem_Data = 8'h22;
    tick();
    check("post_wrap_ir", 32'(bus.IR_out), 32'h2211);
    bus.SC_Clear = 1'b1;
    tick();
    bus.SC_Clear = 1'b0;
    bus.Mem_Data = 8'h33;
    settle();
    check("timeout_sticky", 32'(bus.Timeout), 32'd1);
    check("next_instr_t0", 32'(bus.T_out), 32'd0);
    tick();

    // 5. reset asserted in T1 discards the partial fetch
    check("pre_rst_t1", 32'(bus.T_out), 32'd1);
    rst = 1'b1;
    bus.Mem_Data = 8'h99;
    settle();
    check("rst_t1_mem_cs", 32'(bus.Mem_CS), 32'd1);
    check("rst_t1_pc_inc", 32'(bus.PC_Inc), 32'd0);
    check("rst_t1_ir_en", 32'(bus.IR_Enable), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("after_rst_state", 32'(bus.T_out), 32'd0);
    check("after_rst_ir", 32'(bus.IR_out), 32'h0000);
    check("after_rst_valid", 32'(bus.IR_Valid), 32'd0);
    check("after_rst_timeout", 32'(bus.Timeout), 32'd0);
    check("after_rst_mem_cs", 32'(bus.Mem_CS), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
    $finish;
  end

endmodule
